ppu_vram_arbiter: RTL and testbench
===================================

PPU_VRAM_ARBITER -- requirements
Module: ppu_vram_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: cycles from the mem_rd strobe to valid mem_din (legal 1..7).
REQ-002 Parameter STARVE_MAX, default 255: maximum cycles a pending CPU access waits before it is forced ahead of render (legal 1..255).
REQ-003 clk  input  1  single system clock (25 MHz); all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 rnd_req  input  1  render fetch request, level; held until rnd_ack.
REQ-006 rnd_addr  input  14  render fetch address (NT/AT/pattern), stable while rnd_req is high.
REQ-007 rnd_ack  output  1  one-cycle pulse; rnd_data valid in the same cycle.
REQ-008 rnd_data  output  8  render read data, held until the next render ack.
REQ-009 cpu_req  input  1  one-cycle PPUDATA access pulse.
REQ-010 cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-011 cpu_addr  input  14  CPU access address; sampled with cpu_req.
REQ-012 cpu_wdata  input  8  CPU write data; sampled with cpu_req.
REQ-013 cpu_ack  output  1  one-cycle completion pulse.
REQ-014 cpu_rdata  output  8  CPU read data, valid with cpu_ack, held afterwards.
REQ-015 cpu_busy  output  1  high while a CPU access is pending or in progress.
REQ-016 cpu_overrun  output  1  sticky; set when cpu_req arrives while cpu_busy is high.
REQ-017 mem_addr  output  14  VRAM address, registered.
REQ-018 mem_rd  output  1  one-cycle read strobe, registered.
REQ-019 mem_wr  output  1  one-cycle write strobe, registered.
REQ-020 mem_dout  output  8  VRAM write data, registered.
REQ-021 mem_din  input  8  VRAM read data, valid MEM_LAT cycles after mem_rd.

Function
REQ-022 FSM states: IDLE, RND_RD, CPU_RD, CPU_WR, DONE.
REQ-023 cpu_req while not busy latches we/addr/wdata into a pending register and sets cpu_busy on the next cycle.
REQ-024 cpu_req while busy is dropped, leaves the pending register unchanged, and sets cpu_overrun.
REQ-025 Priority in IDLE: starving CPU > rnd_req > pending CPU.
- Starving CPU = wait counter reached STARVE_MAX.
- The state at the decision cycle is not an access state.
REQ-026 Entering an access state drives the following for exactly one cycle: mem_addr, plus mem_rd (RND_RD/CPU_RD) or mem_wr with mem_dout (CPU_WR).
REQ-027 Read states count MEM_LAT cycles after the strobe, then sample mem_din into rnd_data or cpu_rdata and go to DONE.
REQ-028 CPU_WR goes to DONE on the cycle after the strobe.
REQ-029 DONE pulses the owning ack for one cycle and returns to IDLE; cpu_busy clears in the same cycle as cpu_ack.
REQ-030 An access in progress is never aborted; a request arriving mid-access waits for IDLE.
REQ-031 Render latency with no CPU contention: rnd_req high in IDLE at cycle 0 gives mem_rd at cycle 1 and rnd_ack at cycle 2+MEM_LAT.
REQ-032 The starvation counter is 8 bits, saturates at STARVE_MAX, increments each cycle a CPU access is pending and not granted, and clears on CPU grant.
REQ-033 A cpu_req arriving in the same cycle as a CPU ack is accepted as a new access and does not set overrun.
REQ-034 mem_rd and mem_wr are never high in the same cycle.

Reset
REQ-035 While rst is low:
- state = IDLE;
- all acks, mem_rd, mem_wr, cpu_busy, cpu_overrun = 0;
- mem_addr, mem_dout, rnd_data, cpu_rdata = 0;
- pending register and counters = 0.
REQ-036 Reset asserted mid-access abandons the access with no ack; the first grant after release follows REQ-025.

Structure
REQ-037 The FSM state encodings, the MEM_LAT/STARVE_MAX defaults and the 14-bit VRAM address width constant belong in the shared ppu package.
REQ-038 The CPU pending latch plus overrun flag is one natural sub-module, ppu_cpu_req_latch.

Verification
REQ-039 Render only: rnd_req at 0x2000 with mem model returning 0x5A -> mem_rd at cycle 1, rnd_ack with rnd_data=0x5A at cycle 4 (MEM_LAT=2).
REQ-040 CPU write 0x3F in one pulse to 0x2400 -> one mem_wr with mem_addr=0x2400 and mem_dout=0x3F, then cpu_ack one cycle later; cpu_busy low after the ack.
REQ-041 Simultaneous rnd_req and cpu_req (read) in IDLE -> render served first, CPU read served next; cpu_ack returns the mem value; no overrun.
REQ-042 rnd_req held continuously with STARVE_MAX=4 and a CPU read pending -> CPU granted once the counter reaches 4, then render resumes.
REQ-043 Second cpu_req while busy -> cpu_overrun=1, first access completes with its original address; reset low mid-CPU_RD -> no ack, all outputs 0.

Source files
------------

// File: rtl/ppu_vram_arbiter_pkg.sv
// Purpose : shared types and constants for the PPU VRAM arbiter slice.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package ppu_vram_arbiter_pkg;

  localparam int unsigned VRAM_AW        = 14;   // VRAM address width
  localparam int unsigned DATA_W         = 8;    // VRAM data width
  localparam int unsigned MEM_LAT_DEF    = 2;    // mem_rd strobe to valid mem_din
  localparam int unsigned STARVE_MAX_DEF = 255;  // CPU wait limit before forced grant
  localparam int unsigned LAT_CW         = 3;    // holds 0..7
  localparam int unsigned STARVE_CW      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RND_RD = 3'd1,
    ST_CPU_RD = 3'd2,
    ST_CPU_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // One PPUDATA access as captured from the CPU side.
  typedef struct packed {
    logic               we;
    logic [VRAM_AW-1:0] addr;
    logic [DATA_W-1:0]  wdata;
  } cpu_req_t;

  function automatic logic is_read_state(input state_t s);
    return (s == ST_RND_RD) || (s == ST_CPU_RD);
  endfunction

endpackage

// File: rtl/ppu_vram_arbiter_cpu_latch.sv
// Purpose : holds one pending CPU VRAM access and a sticky overrun flag.
// Latency : request visible as pending (and busy) on the cycle after cpu_req.
// Backpressure: none on the CPU side; a request while busy is dropped and flagged.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_cpu_req/we/addr/wdata   one-cycle CPU access pulse and its fields
//   i_cpu_done                arbiter's cpu ack pulse; frees the slot this cycle
//   o_pend, o_pend_vld        captured access and its valid flag
//   o_busy                    pending or in progress, low during the ack cycle
//   o_overrun                 sticky: a request arrived while busy
module ppu_cpu_req_latch
  import ppu_vram_arbiter_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cpu_req,
  input  logic               i_cpu_we,
  input  logic [VRAM_AW-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0]  i_cpu_wdata,
  input  logic               i_cpu_done,
  output cpu_req_t           o_pend,
  output logic               o_pend_vld,
  output logic               o_busy,
  output logic               o_overrun
);

  cpu_req_t r_pend;
  logic     r_vld;
  logic     r_overrun;
  logic     w_busy;
  logic     w_accept;

  // The slot counts as free during the ack cycle, so a request landing on the
  // ack is taken as a fresh access instead of an overrun.
  assign w_busy   = r_vld & ~i_cpu_done;
  assign w_accept = i_cpu_req & ~w_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend    <= '0;
      r_vld     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend.we    <= i_cpu_we;
        r_pend.addr  <= i_cpu_addr;
        r_pend.wdata <= i_cpu_wdata;
        r_vld        <= 1'b1;
      end else if (i_cpu_done) begin
        r_vld <= 1'b0;
      end
      if (i_cpu_req && w_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_pend     = r_pend;
  assign o_pend_vld = r_vld;
  assign o_busy     = w_busy;
  assign o_overrun  = r_overrun;

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Purpose : arbitrates a single VRAM port between PPU render fetches and CPU PPUDATA accesses.
// Latency : grant in IDLE -> strobe next cycle -> ack 1+MEM_LAT cycles after the strobe (writes: 1 cycle).
// Backpressure: render holds rnd_req until rnd_ack; CPU gets one pending slot, extras dropped and flagged.
//
// Ports:
//   i_clk, i_rst_n                         clock, async active-low reset
//   i_rnd_req, i_rnd_addr                  render fetch request (level) and address
//   o_rnd_ack, o_rnd_data                  render completion pulse, data held until next ack
//   i_cpu_req, i_cpu_we, i_cpu_addr,
//   i_cpu_wdata                            CPU access pulse and fields
//   o_cpu_ack, o_cpu_rdata                 CPU completion pulse, read data held afterwards
//   o_cpu_busy, o_cpu_overrun              CPU slot occupied / sticky dropped-request flag
//   o_mem_addr, o_mem_rd, o_mem_wr,
//   o_mem_dout, i_mem_din                  registered VRAM port, read data MEM_LAT after mem_rd
module ppu_vram_arbiter
  import ppu_vram_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rnd_req,
  input  logic [VRAM_AW-1:0] i_rnd_addr,
  output logic               o_rnd_ack,
  output logic [DATA_W-1:0]  o_rnd_data,
  input  logic               i_cpu_req,
  input  logic               i_cpu_we,
  input  logic [VRAM_AW-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0]  i_cpu_wdata,
  output logic               o_cpu_ack,
  output logic [DATA_W-1:0]  o_cpu_rdata,
  output logic               o_cpu_busy,
  output logic               o_cpu_overrun,
  output logic [VRAM_AW-1:0] o_mem_addr,
  output logic               o_mem_rd,
  output logic               o_mem_wr,
  output logic [DATA_W-1:0]  o_mem_dout,
  input  logic [DATA_W-1:0]  i_mem_din
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LAT_CW-1:0]      r_lat_cnt;
  logic [STARVE_CW-1:0]   r_wait_cnt;
  logic                   r_cpu_active;  // current/last grant belongs to the CPU
  logic [VRAM_AW-1:0]     r_mem_addr;
  logic                   r_mem_rd;
  logic                   r_mem_wr;
  logic [DATA_W-1:0]      r_mem_dout;
  logic [DATA_W-1:0]      r_rnd_data;
  logic [DATA_W-1:0]      r_cpu_rdata;

  cpu_req_t               w_pend;
  logic                   w_pend_vld;
  logic                   w_cpu_busy;
  logic                   w_cpu_overrun;
  logic                   w_cpu_waiting;
  logic                   w_starving;
  logic                   w_lat_done;
  logic                   w_grant_rnd;
  logic                   w_grant_cpu;
  logic                   w_rnd_ack;
  logic                   w_cpu_ack;

  ppu_cpu_req_latch u_cpu_latch (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cpu_req   (i_cpu_req),
    .i_cpu_we    (i_cpu_we),
    .i_cpu_addr  (i_cpu_addr),
    .i_cpu_wdata (i_cpu_wdata),
    .i_cpu_done  (w_cpu_ack),
    .o_pend      (w_pend),
    .o_pend_vld  (w_pend_vld),
    .o_busy      (w_cpu_busy),
    .o_overrun   (w_cpu_overrun)
  );

  // A pending access that has not yet been granted is the one that ages.
  assign w_cpu_waiting = w_pend_vld & ~r_cpu_active;
  assign w_starving    = w_cpu_waiting && (r_wait_cnt == STARVE_CW'(STARVE_MAX));
  // The read strobe went out on the first read-state cycle with the counter at 0,
  // so mem_din is valid when the counter reaches MEM_LAT.
  assign w_lat_done    = (r_lat_cnt == LAT_CW'(MEM_LAT));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_starving) begin
          w_state_nxt = w_pend.we ? ST_CPU_WR : ST_CPU_RD;
        end else if (i_rnd_req) begin
          w_state_nxt = ST_RND_RD;
        end else if (w_cpu_waiting) begin
          w_state_nxt = w_pend.we ? ST_CPU_WR : ST_CPU_RD;
        end
      end
      ST_RND_RD, ST_CPU_RD: begin
        if (w_lat_done) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_CPU_WR: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / grant decode.
  always_comb begin
    w_grant_rnd = 1'b0;
    w_grant_cpu = 1'b0;
    w_rnd_ack   = 1'b0;
    w_cpu_ack   = 1'b0;
    if (r_state == ST_IDLE) begin
      w_grant_rnd = (w_state_nxt == ST_RND_RD);
      w_grant_cpu = (w_state_nxt == ST_CPU_RD) || (w_state_nxt == ST_CPU_WR);
    end
    if (r_state == ST_DONE) begin
      w_rnd_ack = ~r_cpu_active;
      w_cpu_ack = r_cpu_active;
    end
  end

  // Memory port: strobes last exactly one cycle, address/data hold until the next grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_dout <= '0;
    end else begin
      r_mem_rd <= w_grant_rnd | (w_grant_cpu & ~w_pend.we);
      r_mem_wr <= w_grant_cpu & w_pend.we;
      if (w_grant_rnd) begin
        r_mem_addr <= i_rnd_addr;
      end else if (w_grant_cpu) begin
        r_mem_addr <= w_pend.addr;
      end
      if (w_grant_cpu && w_pend.we) begin
        r_mem_dout <= w_pend.wdata;
      end
    end
  end

  // Latency counter, ownership and read-data capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lat_cnt    <= '0;
      r_cpu_active <= 1'b0;
      r_rnd_data   <= '0;
      r_cpu_rdata  <= '0;
    end else begin
      if (is_read_state(r_state)) begin
        r_lat_cnt <= r_lat_cnt + 1'b1;
      end else begin
        r_lat_cnt <= '0;
      end

      if (w_grant_cpu) begin
        r_cpu_active <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_cpu_active <= 1'b0;
      end

      if (r_state == ST_RND_RD && w_lat_done) begin
        r_rnd_data <= i_mem_din;
      end
      if (r_state == ST_CPU_RD && w_lat_done) begin
        r_cpu_rdata <= i_mem_din;
      end
    end
  end

  // Starvation counter: ages while a CPU access waits, saturates, clears on grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_grant_cpu) begin
      r_wait_cnt <= '0;
    end else if (w_cpu_waiting && (r_wait_cnt != STARVE_CW'(STARVE_MAX))) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign o_rnd_ack     = w_rnd_ack;
  assign o_rnd_data    = r_rnd_data;
  assign o_cpu_ack     = w_cpu_ack;
  assign o_cpu_rdata   = r_cpu_rdata;
  assign o_cpu_busy    = w_cpu_busy;
  assign o_cpu_overrun = w_cpu_overrun;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_rd      = r_mem_rd;
  assign o_mem_wr      = r_mem_wr;
  assign o_mem_dout    = r_mem_dout;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Purpose : directed self-checking bench for ppu_vram_arbiter (MEM_LAT=2, STARVE_MAX=4).
// Latency : cycle-exact expectations, cycle 0 = cycle the stimulus is applied.
// Backpressure: render side holds rnd_req until ack; VRAM model answers 2 cycles after mem_rd.
module tb_ppu_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rnd_req;
  logic [13:0] rnd_addr;
  logic        rnd_ack;
  logic [7:0]  rnd_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_busy;
  logic        cpu_overrun;
  logic [13:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ppu_vram_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rnd_req     (rnd_req),
    .i_rnd_addr    (rnd_addr),
    .o_rnd_ack     (rnd_ack),
    .o_rnd_data    (rnd_data),
    .i_cpu_req     (cpu_req),
    .i_cpu_we      (cpu_we),
    .i_cpu_addr    (cpu_addr),
    .i_cpu_wdata   (cpu_wdata),
    .o_cpu_ack     (cpu_ack),
    .o_cpu_rdata   (cpu_rdata),
    .o_cpu_busy    (cpu_busy),
    .o_cpu_overrun (cpu_overrun),
    .o_mem_addr    (mem_addr),
    .o_mem_rd      (mem_rd),
    .o_mem_wr      (mem_wr),
    .o_mem_dout    (mem_dout),
    .i_mem_din     (mem_din)
  );

  // VRAM model: fixed contents plus the most recent write; read data appears
  // exactly 2 cycles after mem_rd and is 0 otherwise.
  logic        wr_vld = 1'b0;
  logic [13:0] wr_addr = '0;
  logic [7:0]  wr_dat = '0;
  logic [7:0]  rd_pipe0 = '0;
  logic [7:0]  rd_pipe1 = '0;

  function automatic logic [7:0] mem_val(input logic [13:0] a);
    if (wr_vld && a == wr_addr) return wr_dat;
    case (a)
      14'h2000: return 8'h5A;
      14'h23C0: return 8'h11;
      14'h0123: return 8'hA7;
      14'h0040: return 8'h22;
      14'h1000: return 8'h99;
      14'h0ABC: return 8'h5C;
      default:  return 8'hC3;
    endcase
  endfunction

  always @(posedge clk) begin
    rd_pipe0 <= mem_rd ? mem_val(mem_addr) : 8'h00;
    rd_pipe1 <= rd_pipe0;
    if (mem_wr) begin
      wr_vld  <= 1'b1;
      wr_addr <= mem_addr;
      wr_dat  <= mem_dout;
    end
  end
  assign mem_din = rd_pipe1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rnd_req = 1'b0; rnd_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(2);
    n_cmp++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_strobes: rd=%b wr=%b want 0 0", mem_rd, mem_wr); end
    n_cmp++; if (mem_addr !== 14'h0 || mem_dout !== 8'h0) begin n_bad++; $display("FAIL reset_mem_bus: addr=%h dout=%h want 0 0", mem_addr, mem_dout); end
    n_cmp++; if (rnd_ack !== 1'b0 || cpu_ack !== 1'b0) begin n_bad++; $display("FAIL reset_acks: rnd=%b cpu=%b want 0 0", rnd_ack, cpu_ack); end
    n_cmp++; if (rnd_data !== 8'h0 || cpu_rdata !== 8'h0) begin n_bad++; $display("FAIL reset_data: rnd=%h cpu=%h want 0 0", rnd_data, cpu_rdata); end
    n_cmp++; if (cpu_busy !== 1'b0 || cpu_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_flags: busy=%b ovr=%b want 0 0", cpu_busy, cpu_overrun); end
    rst_n = 1'b1;
    tick(2);
    n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL reset_idle_rd: got %b want 0", mem_rd); end
  endtask

  task automatic test_render;
    rnd_req = 1'b1; rnd_addr = 14'h2000;                      // c0
    tick(1);                                                  // c1
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 14'h2000) begin n_bad++; $display("FAIL render_strobe: rd=%b addr=%h want 1 2000", mem_rd, mem_addr); end
    n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL render_no_wr: got %b want 0", mem_wr); end
    tick(1);                                                  // c2
    n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL render_strobe_len: got %b want 0", mem_rd); end
    tick(1);                                                  // c3
    n_cmp++; if (rnd_ack !== 1'b0) begin n_bad++; $display("FAIL render_early_ack: got %b want 0", rnd_ack); end
    tick(1);                                                  // c4
    n_cmp++; if (rnd_ack !== 1'b1 || rnd_data !== 8'h5A) begin n_bad++; $display("FAIL render_ack: ack=%b data=%h want 1 5a", rnd_ack, rnd_data); end
    rnd_req = 1'b0;
    tick(1);                                                  // c5
    n_cmp++; if (rnd_ack !== 1'b0 || rnd_data !== 8'h5A) begin n_bad++; $display("FAIL render_hold: ack=%b data=%h want 0 5a", rnd_ack, rnd_data); end
    tick(1);
  endtask

  task automatic test_cpu_write;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2400; cpu_wdata = 8'h3F;  // c0
    tick(1);                                                  // c1
    cpu_req = 1'b0;
    n_cmp++; if (cpu_busy !== 1'b1 || mem_wr !== 1'b0) begin n_bad++; $display("FAIL cpuwr_busy: busy=%b wr=%b want 1 0", cpu_busy, mem_wr); end
    tick(1);                                                  // c2
    n_cmp++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin n_bad++; $display("FAIL cpuwr_strobe: wr=%b rd=%b want 1 0", mem_wr, mem_rd); end
    n_cmp++; if (mem_addr !== 14'h2400 || mem_dout !== 8'h3F) begin n_bad++; $display("FAIL cpuwr_bus: addr=%h dout=%h want 2400 3f", mem_addr, mem_dout); end
    n_cmp++; if (cpu_ack !== 1'b0 || cpu_busy !== 1'b1) begin n_bad++; $display("FAIL cpuwr_mid: ack=%b busy=%b want 0 1", cpu_ack, cpu_busy); end
    tick(1);                                                  // c3
    n_cmp++; if (cpu_ack !== 1'b1 || cpu_busy !== 1'b0 || mem_wr !== 1'b0) begin n_bad++; $display("FAIL cpuwr_ack: ack=%b busy=%b wr=%b want 1 0 0", cpu_ack, cpu_busy, mem_wr); end
    tick(1);                                                  // c4
    n_cmp++; if (cpu_ack !== 1'b0 || cpu_busy !== 1'b0) begin n_bad++; $display("FAIL cpuwr_after: ack=%b busy=%b want 0 0", cpu_ack, cpu_busy); end
    n_cmp++; if (wr_vld !== 1'b1 || wr_addr !== 14'h2400 || wr_dat !== 8'h3F) begin n_bad++; $display("FAIL cpuwr_mem: vld=%b addr=%h dat=%h want 1 2400 3f", wr_vld, wr_addr, wr_dat); end
  endtask

  task automatic test_simultaneous;
    rnd_req = 1'b1; rnd_addr = 14'h23C0;                      // c0
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
    tick(1);                                                  // c1
    cpu_req = 1'b0;
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 14'h23C0) begin n_bad++; $display("FAIL simul_render_first: rd=%b addr=%h want 1 23c0", mem_rd, mem_addr); end
    tick(3);                                                  // c4
    n_cmp++; if (rnd_ack !== 1'b1 || rnd_data !== 8'h11) begin n_bad++; $display("FAIL simul_rnd_ack: ack=%b data=%h want 1 11", rnd_ack, rnd_data); end
    rnd_req = 1'b0;
    tick(1);                                                  // c5
    n_cmp++; if (cpu_busy !== 1'b1 || cpu_ack !== 1'b0) begin n_bad++; $display("FAIL simul_cpu_wait: busy=%b ack=%b want 1 0", cpu_busy, cpu_ack); end
    tick(1);                                                  // c6
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 14'h0123) begin n_bad++; $display("FAIL simul_cpu_strobe: rd=%b addr=%h want 1 0123", mem_rd, mem_addr); end
    tick(3);                                                  // c9
    n_cmp++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA7) begin n_bad++; $display("FAIL simul_cpu_ack: ack=%b data=%h want 1 a7", cpu_ack, cpu_rdata); end
    n_cmp++; if (cpu_overrun !== 1'b0 || cpu_busy !== 1'b0) begin n_bad++; $display("FAIL simul_flags: ovr=%b busy=%b want 0 0", cpu_overrun, cpu_busy); end
    tick(1);
  endtask

  task automatic test_starvation;
    rnd_req = 1'b1; rnd_addr = 14'h0040;                      // c0, held throughout
    tick(1);                                                  // c1
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 14'h0040) begin n_bad++; $display("FAIL starve_r1: rd=%b addr=%h want 1 0040", mem_rd, mem_addr); end
    tick(1);                                                  // c2
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1000;
    tick(1);                                                  // c3
    cpu_req = 1'b0;
    tick(1);                                                  // c4
    n_cmp++; if (rnd_ack !== 1'b1 || rnd_data !== 8'h22) begin n_bad++; $display("FAIL starve_r1_ack: ack=%b data=%h want 1 22", rnd_ack, rnd_data); end
    tick(2);                                                  // c6: counter only 2 at c5 -> render wins
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 14'h0040) begin n_bad++; $display("FAIL starve_r2: rd=%b addr=%h want 1 0040", mem_rd, mem_addr); end
    tick(3);                                                  // c9
    n_cmp++; if (rnd_ack !== 1'b1) begin n_bad++; $display("FAIL starve_r2_ack: got %b want 1", rnd_ack); end
    tick(2);                                                  // c11: counter saturated -> CPU forced
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 14'h1000) begin n_bad++; $display("FAIL starve_cpu_grant: rd=%b addr=%h want 1 1000", mem_rd, mem_addr); end
    tick(3);                                                  // c14
    n_cmp++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h99 || rnd_ack !== 1'b0) begin n_bad++; $display("FAIL starve_cpu_ack: ack=%b data=%h rack=%b want 1 99 0", cpu_ack, cpu_rdata, rnd_ack); end
    tick(2);                                                  // c16
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 14'h0040) begin n_bad++; $display("FAIL starve_resume: rd=%b addr=%h want 1 0040", mem_rd, mem_addr); end
    tick(3);                                                  // c19
    n_cmp++; if (rnd_ack !== 1'b1) begin n_bad++; $display("FAIL starve_r3_ack: got %b want 1", rnd_ack); end
    rnd_req = 1'b0;
    tick(2);
  endtask

  task automatic test_overrun;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0ABC;       // c0
    tick(1);                                                  // c1
    n_cmp++; if (cpu_busy !== 1'b1) begin n_bad++; $display("FAIL ovr_busy: got %b want 1", cpu_busy); end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0DEF; cpu_wdata = 8'hEE;
    tick(1);                                                  // c2
    cpu_req = 1'b0;
    n_cmp++; if (cpu_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", cpu_overrun); end
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 14'h0ABC) begin n_bad++; $display("FAIL ovr_orig_addr: rd=%b addr=%h want 1 0abc", mem_rd, mem_addr); end
    tick(3);                                                  // c5
    n_cmp++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5C) begin n_bad++; $display("FAIL ovr_ack: ack=%b data=%h want 1 5c", cpu_ack, cpu_rdata); end
    tick(1);                                                  // c6
    n_cmp++; if (mem_wr !== 1'b0 || cpu_busy !== 1'b0 || cpu_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_dropped: wr=%b busy=%b ovr=%b want 0 0 1", mem_wr, cpu_busy, cpu_overrun); end
    tick(1);                                                  // c7
    n_cmp++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin n_bad++; $display("FAIL ovr_quiet: wr=%b rd=%b want 0 0", mem_wr, mem_rd); end
  endtask

  task automatic test_reset_mid_access;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0ABC;       // c0
    tick(1);                                                  // c1
    cpu_req = 1'b0;
    tick(1);                                                  // c2
    n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL rstmid_strobe: got %b want 1", mem_rd); end
    tick(1);                                                  // c3, inside CPU_RD
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cpu_busy !== 1'b0 || cpu_overrun !== 1'b0 || cpu_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_flags: busy=%b ovr=%b ack=%b want 0 0 0", cpu_busy, cpu_overrun, cpu_ack); end
    n_cmp++; if (mem_addr !== 14'h0 || mem_rd !== 1'b0 || rnd_data !== 8'h0 || cpu_rdata !== 8'h0) begin n_bad++; $display("FAIL rstmid_data: addr=%h rd=%b rnd=%h cpu=%h want 0 0 0 0", mem_addr, mem_rd, rnd_data, cpu_rdata); end
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      n_cmp++; if (cpu_ack !== 1'b0 || mem_rd !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_ack[%0d]: ack=%b rd=%b want 0 0", i, cpu_ack, mem_rd); end
    end
  endtask

  task automatic test_back_to_back;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 8'h77;  // c0
    tick(1);                                                  // c1
    cpu_req = 1'b0;
    tick(1);                                                  // c2
    n_cmp++; if (mem_wr !== 1'b1 || mem_addr !== 14'h0100) begin n_bad++; $display("FAIL b2b_wr: wr=%b addr=%h want 1 0100", mem_wr, mem_addr); end
    tick(1);                                                  // c3
    n_cmp++; if (cpu_ack !== 1'b1) begin n_bad++; $display("FAIL b2b_ack1: got %b want 1", cpu_ack); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0100;
    tick(1);                                                  // c4
    cpu_req = 1'b0;
    n_cmp++; if (cpu_busy !== 1'b1 || cpu_overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_accept: busy=%b ovr=%b want 1 0", cpu_busy, cpu_overrun); end
    tick(1);                                                  // c5
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 14'h0100) begin n_bad++; $display("FAIL b2b_rd: rd=%b addr=%h want 1 0100", mem_rd, mem_addr); end
    tick(3);                                                  // c8
    n_cmp++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h77) begin n_bad++; $display("FAIL b2b_ack2: ack=%b data=%h want 1 77", cpu_ack, cpu_rdata); end
    tick(1);
  endtask

  initial begin
    test_reset();
    test_render();
    test_cpu_write();
    test_simultaneous();
    test_starvation();
    test_overrun();
    test_reset_mid_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
